// File: rtl/pu_loader.sv
// pu_loader: write-side driver for the img2col processing unit's window
// register file.
//
// Pixel pairs arrive on a valid/ready stream and are written through the PU's
// dual write port. When a window is complete, the loader pulses `start` and
// waits for `pu_done`. Round 0 of a row loads the full window at addresses
// 0..weight_size-1. Later rounds load only the kernel_dim new-column pixels at
// the top addresses, because the PU keeps the other pixels of the window.
//
// Ports:
//   clk        in   rising-edge clock
//   nrst       in   asynchronous reset, active-high
//   go         in   begin a row (sampled in IDLE only)
//   num_rounds in   windows per row, latched on go (0 treated as 1)
//   s_data1    in   lower-address pixel of a beat
//   s_data2    in   higher-address pixel of a beat
//   s_valid    in   beat valid
//   s_ready    out  beat accepted when s_valid && s_ready
//   pu_done    in   PU finished the current window (one-cycle pulse)
//   wr_ctrl_g  out  PU register-file write enable
//   adrs_in1   out  lane-1 write address
//   adrs_in2   out  lane-2 write address
//   new1       out  lane-1 write data
//   new2       out  lane-2 write data
//   start      out  one-cycle PU start pulse
//   round      out  window index within the row
//   busy       out  high from accepted go until row_done
//   row_done   out  one-cycle pulse after the last window's pu_done
module pu_loader #(
    parameter int data_width  = 16,
    parameter int address_num = 5,
    parameter int weight_size = 25,
    parameter int kernel_dim  = 5
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   go,
    input  logic [5:0]             num_rounds,
    input  logic [data_width-1:0]  s_data1,
    input  logic [data_width-1:0]  s_data2,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   pu_done,
    output logic                   wr_ctrl_g,
    output logic [address_num-1:0] adrs_in1,
    output logic [address_num-1:0] adrs_in2,
    output logic [data_width-1:0]  new1,
    output logic [data_width-1:0]  new2,
    output logic                   start,
    output logic [5:0]             round,
    output logic                   busy,
    output logic                   row_done
);

    // Both window sizes are odd and start at even addresses. The final beat
    // is therefore the one whose lane-1 address is the top address.
    localparam logic [address_num-1:0] LAST_ADRS  = address_num'(weight_size - 1);
    localparam logic [address_num-1:0] SLIDE_BASE = address_num'(weight_size - kernel_dim);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   accept_s;
    logic                   last_beat_s;
    logic                   last_round_s;
    logic                   row_go_s;
    logic                   next_round_s;
    logic                   finish_s;

    logic [address_num-1:0] addr_r;
    logic [5:0]             nr_r;
    logic [5:0]             round_r;
    logic                   busy_r;
    logic                   row_done_r;
    logic                   start_r;
    logic                   wr_ctrl_g_r;
    logic [address_num-1:0] adrs_in1_r;
    logic [address_num-1:0] adrs_in2_r;
    logic [data_width-1:0]  new1_r;
    logic [data_width-1:0]  new2_r;

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        row_go_s     = 1'b0;
        next_round_s = 1'b0;
        finish_s     = 1'b0;
        last_beat_s  = (addr_r == LAST_ADRS);
        last_round_s = (round_r == (nr_r - 6'd1));
        case (state_r)
            IDLE: begin
                if (go) begin
                    row_go_s = 1'b1;
                    state_s  = LOAD;
                end else begin
                    state_s  = IDLE;
                end
            end
            LOAD: begin
                if (s_valid) begin
                    accept_s = 1'b1;
                    if (last_beat_s) begin
                        state_s = START;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            START: begin
                // Any pu_done seen here is stale and is ignored.
                state_s = WAIT;
            end
            WAIT: begin
                if (pu_done) begin
                    if (last_round_s) begin
                        finish_s     = 1'b1;
                        state_s      = IDLE;
                    end else begin
                        next_round_s = 1'b1;
                        state_s      = LOAD;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Row bookkeeping: rounds, the next write address, and busy.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            nr_r    <= 6'd0;
            round_r <= 6'd0;
            addr_r  <= {address_num{1'b0}};
            busy_r  <= 1'b0;
        end else if (row_go_s) begin
            nr_r    <= (num_rounds == 6'd0) ? 6'd1 : num_rounds;
            round_r <= 6'd0;
            addr_r  <= {address_num{1'b0}};
            busy_r  <= 1'b1;
        end else if (next_round_s) begin
            round_r <= round_r + 6'd1;
            addr_r  <= SLIDE_BASE;
        end else if (finish_s) begin
            busy_r  <= 1'b0;
        end else if (accept_s) begin
            addr_r  <= addr_r + address_num'(2);
        end else begin
            addr_r  <= addr_r;
        end
    end

    // Registered write port. On the final beat, lane 2 duplicates lane 1.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            wr_ctrl_g_r <= 1'b0;
            adrs_in1_r  <= {address_num{1'b0}};
            adrs_in2_r  <= {address_num{1'b0}};
            new1_r      <= {data_width{1'b0}};
            new2_r      <= {data_width{1'b0}};
        end else begin
            wr_ctrl_g_r <= accept_s;
            if (accept_s) begin
                adrs_in1_r <= addr_r;
                adrs_in2_r <= last_beat_s ? addr_r : (addr_r + address_num'(1));
                new1_r     <= s_data1;
                new2_r     <= last_beat_s ? s_data1 : s_data2;
            end else begin
                adrs_in1_r <= adrs_in1_r;
                adrs_in2_r <= adrs_in2_r;
                new1_r     <= new1_r;
                new2_r     <= new2_r;
            end
        end
    end

    // Start pulse follows the START cycle, one cycle after the last write
    // appears. The row_done pulse follows the last pu_done.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            start_r    <= 1'b0;
            row_done_r <= 1'b0;
        end else begin
            start_r    <= (state_r == START);
            row_done_r <= finish_s;
        end
    end

    assign s_ready   = (state_r == LOAD);
    assign wr_ctrl_g = wr_ctrl_g_r;
    assign adrs_in1  = adrs_in1_r;
    assign adrs_in2  = adrs_in2_r;
    assign new1      = new1_r;
    assign new2      = new2_r;
    assign start     = start_r;
    assign round     = round_r;
    assign busy      = busy_r;
    assign row_done  = row_done_r;

endmodule

// File: tb/tb_pu_loader.sv
// Directed testbench for pu_loader. It drives inputs 1 time unit after the
// rising edge and samples outputs at that same point.
module tb_pu_loader;

    logic        clk = 1'b0;
    logic        nrst;
    logic        go;
    logic [5:0]  num_rounds;
    logic [15:0] s_data1;
    logic [15:0] s_data2;
    logic        s_valid;
    logic        s_ready;
    logic        pu_done;
    logic        wr_ctrl_g;
    logic [4:0]  adrs_in1;
    logic [4:0]  adrs_in2;
    logic [15:0] new1;
    logic [15:0] new2;
    logic        start;
    logic [5:0]  round;
    logic        busy;
    logic        row_done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pu_loader dut (
        .clk        (clk),
        .nrst       (nrst),
        .go         (go),
        .num_rounds (num_rounds),
        .s_data1    (s_data1),
        .s_data2    (s_data2),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .pu_done    (pu_done),
        .wr_ctrl_g  (wr_ctrl_g),
        .adrs_in1   (adrs_in1),
        .adrs_in2   (adrs_in2),
        .new1       (new1),
        .new2       (new2),
        .start      (start),
        .round      (round),
        .busy       (busy),
        .row_done   (row_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_row(input logic [5:0] nr);
        num_rounds = nr;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        check("busy_on", 32'(busy), 1);
        check("round_start", 32'(round), 0);
        check("ready_in_load", 32'(s_ready), 1);
    endtask

    // Streams one window that begins at address base. Pixel p has the value
    // first+p. gap_after inserts two idle cycles after that beat. go_noise
    // holds go high during LOAD and WAIT. early_done pulses pu_done in the
    // START cycle.
    task automatic run_window(input int base, input int first, input int exp_round,
                              input bit last, input int gap_after,
                              input bit go_noise, input bit early_done);
        int nbeats;
        bit fin;
        nbeats = (base == 0) ? 13 : 3;
        for (int k = 0; k < nbeats; k++) begin
            fin     = (k == nbeats - 1);
            s_valid = 1'b1;
            s_data1 = 16'(first + 2 * k);
            s_data2 = fin ? 16'hDEAD : 16'(first + 2 * k + 1);
            go      = go_noise;
            @(posedge clk); #1;
            s_valid = 1'b0;
            s_data1 = 16'hBEEF;
            s_data2 = 16'hBEEF;
            check("wr_en", 32'(wr_ctrl_g), 1);
            check("adrs1", 32'(adrs_in1), base + 2 * k);
            check("adrs2", 32'(adrs_in2), fin ? base + 2 * k : base + 2 * k + 1);
            check("new1", 32'(new1), first + 2 * k);
            check("new2", 32'(new2), fin ? first + 2 * k : first + 2 * k + 1);
            check("round_hold", 32'(round), exp_round);
            check("no_early_start", 32'(start), 0);
            if (k == gap_after) begin
                for (int g = 0; g < 2; g++) begin
                    @(posedge clk); #1;
                    check("gap_no_wr", 32'(wr_ctrl_g), 0);
                    check("gap_hold_adrs", 32'(adrs_in1), base + 2 * k);
                end
            end
        end
        // The loader is now in the START cycle.
        pu_done = early_done;
        @(posedge clk); #1;
        pu_done = 1'b0;
        check("start_pulse", 32'(start), 1);
        check("wr_idle_at_start", 32'(wr_ctrl_g), 0);
        if (early_done) begin
            @(posedge clk); #1;
            check("start_single", 32'(start), 0);
            check("early_done_busy", 32'(busy), 1);
            check("early_done_no_row_done", 32'(row_done), 0);
            check("early_done_round", 32'(round), exp_round);
        end
        pu_done = 1'b1;
        @(posedge clk); #1;
        pu_done = 1'b0;
        go      = 1'b0;
        if (last) begin
            check("row_done_pulse", 32'(row_done), 1);
            check("busy_off", 32'(busy), 0);
            check("idle_not_ready", 32'(s_ready), 0);
            @(posedge clk); #1;
            check("row_done_single", 32'(row_done), 0);
        end else begin
            check("round_next", 32'(round), exp_round + 1);
            check("reload_ready", 32'(s_ready), 1);
            check("busy_kept", 32'(busy), 1);
            check("no_row_done", 32'(row_done), 0);
            check("start_low", 32'(start), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst       = 1'b1;
        go         = 1'b0;
        num_rounds = 6'd0;
        s_data1    = 16'd0;
        s_data2    = 16'd0;
        s_valid    = 1'b0;
        pu_done    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_wr", 32'(wr_ctrl_g), 0);
        check("rst_start", 32'(start), 0);
        nrst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 32'(s_ready), 0);
        check("idle_busy", 32'(busy), 0);

        // Assert reset in the middle of round 0, after six beats.
        start_row(6'd1);
        s_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            s_data1 = 16'(100 + 2 * k);
            s_data2 = 16'(101 + 2 * k);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("pre_rst_wr", 32'(wr_ctrl_g), 1);
        nrst = 1'b1;
        #1;
        check("mid_rst_wr", 32'(wr_ctrl_g), 0);
        check("mid_rst_adrs1", 32'(adrs_in1), 0);
        check("mid_rst_adrs2", 32'(adrs_in2), 0);
        check("mid_rst_new1", 32'(new1), 0);
        check("mid_rst_new2", 32'(new2), 0);
        check("mid_rst_start", 32'(start), 0);
        check("mid_rst_round", 32'(round), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_row_done", 32'(row_done), 0);
        check("mid_rst_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
        nrst = 1'b0;

        // Full window after the reset: pixels 1..25, addresses restart at 0/1.
        start_row(6'd1);
        run_window(0, 1, 0, 1'b1, -1, 1'b0, 1'b0);

        // Three sliding rounds. Round 0 has s_valid gaps (1,0,0,1), round 1
        // has go noise, and round 2 has pu_done in its START cycle.
        start_row(6'd3);
        run_window(0, 1, 0, 1'b0, 0, 1'b0, 1'b0);
        run_window(20, 50, 1, 1'b0, -1, 1'b1, 1'b0);
        run_window(20, 60, 2, 1'b1, -1, 1'b0, 1'b1);

        // num_rounds of 0 runs a single window.
        start_row(6'd0);
        run_window(0, 200, 0, 1'b1, -1, 1'b0, 1'b0);
        check("final_idle", 32'(s_ready), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
